// File: rtl/cr_tcipif_dummy_slave.sv
// cr_tcipif_dummy_slave
//   Default slave for a TCIPIF bus segment that has no real target. It
//   grants and completes every accepted request after a fixed latency. It
//   either errors the request (RESP_ERR=1) or returns OK with zero read data.
//   It also keeps a small log of the first error plus a saturating count.
//
// Parameters
//   DW        read data width
//   AW        address width
//   LAT       accept-to-completion latency in cycles (1..15)
//   RESP_ERR  1 = error response, 0 = OK response
//
// Ports
//   forever_cpuclk               clock, rising edge
//   cpurst_b                     asynchronous reset, active low
//   bmu_tcipif_bus_req           request valid
//   bmu_tcipif_bus_acc_deny      request denied upstream, no response owed
//   bmu_tcipif_bus_addr          request address
//   bmu_tcipif_bus_write         1 = write, 0 = read
//   tcipif_err_clr               clear error flag and count
//   tcipif_bmu_bus_grnt          request granted this cycle
//   tcipif_bmu_bus_trans_cmplt   completion pulse
//   tcipif_bmu_bus_acc_err       completion carries an error
//   tcipif_bmu_bus_data_vld      read data valid
//   tcipif_bmu_bus_data          read data (always zero)
//   tcipif_err_vld               first error captured
//   tcipif_err_addr              address of first logged error
//   tcipif_err_write             direction of first logged error
//   tcipif_err_cnt               saturating error count
//
// state | meaning
// IDLE  | nothing outstanding, request can be granted
// WAIT  | request accepted, latency counter running, grant blocked
// RESP  | completion cycle, a new request can be granted
module cr_tcipif_dummy_slave #(
   parameter int DW       = 32,
   parameter int AW       = 32,
   parameter int LAT      = 1,
   parameter int RESP_ERR = 1
) (
   input  logic          forever_cpuclk,
   input  logic          cpurst_b,
   input  logic          bmu_tcipif_bus_req,
   input  logic          bmu_tcipif_bus_acc_deny,
   input  logic [AW-1:0] bmu_tcipif_bus_addr,
   input  logic          bmu_tcipif_bus_write,
   input  logic          tcipif_err_clr,
   output logic          tcipif_bmu_bus_grnt,
   output logic          tcipif_bmu_bus_trans_cmplt,
   output logic          tcipif_bmu_bus_acc_err,
   output logic          tcipif_bmu_bus_data_vld,
   output logic [DW-1:0] tcipif_bmu_bus_data,
   output logic          tcipif_err_vld,
   output logic [AW-1:0] tcipif_err_addr,
   output logic          tcipif_err_write,
   output logic [7:0]    tcipif_err_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // WAIT holds LAT-1 cycles: the load value plus the cycle that reads zero.
   localparam logic [3:0] CNT_LOAD = (LAT >= 2) ? 4'(LAT - 2) : 4'd0;
   localparam bit         ERR_MODE = (RESP_ERR != 0);
   localparam bit         LAT_ONE  = (LAT <= 1);

   state_t          state;
   logic [3:0]      cnt;
   logic [AW-1:0]   cap_addr;
   logic            cap_write;
   logic            accept;
   logic            resp;
   logic            resp_err;

   // The grant is gated by reset so that every output reads zero while
   // reset is held, even if a requester keeps req high.
   assign tcipif_bmu_bus_grnt = cpurst_b & bmu_tcipif_bus_req & (state != ST_WAIT);
   assign accept              = tcipif_bmu_bus_grnt & ~bmu_tcipif_bus_acc_deny;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         cap_addr  <= '0;
         cap_write <= 1'b0;
      end else begin
         if (accept) begin
            cap_addr  <= bmu_tcipif_bus_addr;
            cap_write <= bmu_tcipif_bus_write;
         end
         case (state)
            ST_IDLE, ST_RESP: begin
               if (accept) begin
                  if (LAT_ONE) begin
                     state <= ST_RESP;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= CNT_LOAD;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (cnt == 4'd0) begin
                  state <= ST_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign resp                       = (state == ST_RESP);
   assign resp_err                   = resp & ERR_MODE;
   assign tcipif_bmu_bus_trans_cmplt = resp;
   assign tcipif_bmu_bus_acc_err     = resp_err;
   assign tcipif_bmu_bus_data_vld    = resp & ~ERR_MODE & ~cap_write;
   assign tcipif_bmu_bus_data        = '0;

   // A new error wins over a coincident clear, so the log restarts with
   // that error instead of losing it.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         tcipif_err_vld   <= 1'b0;
         tcipif_err_addr  <= '0;
         tcipif_err_write <= 1'b0;
         tcipif_err_cnt   <= 8'd0;
      end else if (resp_err) begin
         if (tcipif_err_clr) begin
            tcipif_err_cnt <= 8'd1;
         end else if (tcipif_err_cnt != 8'hFF) begin
            tcipif_err_cnt <= tcipif_err_cnt + 8'd1;
         end
         if (!tcipif_err_vld || tcipif_err_clr) begin
            tcipif_err_addr  <= cap_addr;
            tcipif_err_write <= cap_write;
         end
         tcipif_err_vld <= 1'b1;
      end else if (tcipif_err_clr && ERR_MODE) begin
         tcipif_err_vld <= 1'b0;
         tcipif_err_cnt <= 8'd0;
      end
   end

endmodule

// File: tb/tb_cr_tcipif_dummy_slave.sv
// Four slave instances share one stimulus: [0] LAT=1 error, [1] LAT=3 error,
// [2] LAT=1 OK, [3] LAT=5 error. Inputs change 1ns after the rising edge and
// outputs are sampled on the falling edge. A per-instance scoreboard queues
// each expected completion when a request is accepted and checks it off
// when the completion cycle arrives.
module tb_cr_tcipif_dummy_slave;

   localparam int NI = 4;
   localparam int LAT_I [NI] = '{1, 3, 1, 5};
   localparam bit ERR_I [NI] = '{1'b1, 1'b1, 1'b0, 1'b1};

   typedef struct {
      int unsigned cyc;
      logic        wr;
      logic [31:0] addr;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic        deny;
   logic [31:0] addr;
   logic        wr;
   logic        clr;

   logic        grnt_a  [NI];
   logic        cmplt_a [NI];
   logic        err_a   [NI];
   logic        dvld_a  [NI];
   logic [31:0] data_a  [NI];
   logic        evld_a  [NI];
   logic [31:0] eaddr_a [NI];
   logic        ewr_a   [NI];
   logic [7:0]  ecnt_a  [NI];

   int unsigned cyc;
   int unsigned n_vec;
   int unsigned n_miss;

   exp_t        sbq    [NI][$];
   int unsigned free_c [NI];
   logic        m_vld  [NI];
   logic [7:0]  m_cnt  [NI];
   logic [31:0] m_addr [NI];
   logic        m_wr   [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      cr_tcipif_dummy_slave #(
         .DW(32), .AW(32), .LAT(LAT_I[g]), .RESP_ERR(ERR_I[g] ? 1 : 0)
      ) u_dut (
         .forever_cpuclk            (clk),
         .cpurst_b                  (rst_n),
         .bmu_tcipif_bus_req        (req),
         .bmu_tcipif_bus_acc_deny   (deny),
         .bmu_tcipif_bus_addr       (addr),
         .bmu_tcipif_bus_write      (wr),
         .tcipif_err_clr            (clr),
         .tcipif_bmu_bus_grnt       (grnt_a[g]),
         .tcipif_bmu_bus_trans_cmplt(cmplt_a[g]),
         .tcipif_bmu_bus_acc_err    (err_a[g]),
         .tcipif_bmu_bus_data_vld   (dvld_a[g]),
         .tcipif_bmu_bus_data       (data_a[g]),
         .tcipif_err_vld            (evld_a[g]),
         .tcipif_err_addr           (eaddr_a[g]),
         .tcipif_err_write          (ewr_a[g]),
         .tcipif_err_cnt            (ecnt_a[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard and error-log model, evaluated once per cycle.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            n_vec++;
            if ({grnt_a[i], cmplt_a[i], err_a[i], dvld_a[i], evld_a[i], ewr_a[i]} !== 6'b0 ||
                eaddr_a[i] !== 32'h0 || ecnt_a[i] !== 8'h0 || data_a[i] !== 32'h0) begin
               n_miss++;
               $display("FAIL rst_outputs inst%0d cyc%0d: grnt=%b cmplt=%b err=%b vld=%b cnt=%0d, all must be 0",
                        i, cyc, grnt_a[i], cmplt_a[i], err_a[i], evld_a[i], ecnt_a[i]);
            end
            sbq[i].delete();
            free_c[i] = 0;
            m_vld[i]  = 1'b0;
            m_cnt[i]  = 8'd0;
            m_addr[i] = 32'h0;
            m_wr[i]   = 1'b0;
         end else begin
            automatic bit   resp   = (sbq[i].size() > 0) && (sbq[i][0].cyc == cyc);
            automatic logic r_wr   = resp ? sbq[i][0].wr : 1'b0;
            automatic logic [31:0] r_addr = resp ? sbq[i][0].addr : 32'h0;
            automatic bit   e_grnt = req && (cyc >= free_c[i]);
            automatic logic e_dvld = resp && !ERR_I[i] && !r_wr;

            n_vec++;
            if (cmplt_a[i] !== resp) begin
               n_miss++;
               $display("FAIL cmplt inst%0d cyc%0d: got %b exp %b", i, cyc, cmplt_a[i], resp);
            end
            n_vec++;
            if (err_a[i] !== (resp && ERR_I[i]) || dvld_a[i] !== e_dvld || data_a[i] !== 32'h0) begin
               n_miss++;
               $display("FAIL resp_attr inst%0d cyc%0d: acc_err=%b data_vld=%b data=%h exp %b %b 0",
                        i, cyc, err_a[i], dvld_a[i], data_a[i], resp && ERR_I[i], e_dvld);
            end
            n_vec++;
            if (grnt_a[i] !== e_grnt) begin
               n_miss++;
               $display("FAIL grnt inst%0d cyc%0d: got %b exp %b", i, cyc, grnt_a[i], e_grnt);
            end
            n_vec++;
            if (evld_a[i] !== m_vld[i] || ecnt_a[i] !== m_cnt[i] ||
                eaddr_a[i] !== m_addr[i] || ewr_a[i] !== m_wr[i]) begin
               n_miss++;
               $display("FAIL err_log inst%0d cyc%0d: vld=%b cnt=%0d addr=%h wr=%b exp %b %0d %h %b",
                        i, cyc, evld_a[i], ecnt_a[i], eaddr_a[i], ewr_a[i],
                        m_vld[i], m_cnt[i], m_addr[i], m_wr[i]);
            end

            if (resp) void'(sbq[i].pop_front());
            if (resp && ERR_I[i]) begin
               if (!m_vld[i] || clr) begin
                  m_addr[i] = r_addr;
                  m_wr[i]   = r_wr;
               end
               m_cnt[i] = clr ? 8'd1 : ((m_cnt[i] == 8'd255) ? 8'd255 : m_cnt[i] + 8'd1);
               m_vld[i] = 1'b1;
            end else if (clr && ERR_I[i]) begin
               m_vld[i] = 1'b0;
               m_cnt[i] = 8'd0;
            end
            if (e_grnt && !deny) begin
               sbq[i].push_back(exp_t'{cyc: cyc + LAT_I[i], wr: wr, addr: addr});
               free_c[i] = cyc + LAT_I[i];
            end
         end
      end
   end

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         req  = 1'b0;
         deny = 1'b0;
         clr  = 1'b0;
      end
   endtask

   task automatic test_reset;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_vec++;
         if (cmplt_a[0] !== 1'b0 || evld_a[0] !== 1'b0 || ecnt_a[0] !== 8'd0 || grnt_a[0] !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_state: cmplt=%b vld=%b cnt=%0d grnt=%b exp all 0",
                     cmplt_a[0], evld_a[0], ecnt_a[0], grnt_a[0]);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_single_err;
      @(posedge clk); #1;
      req  = 1'b1;
      addr = 32'h0000_1000;
      wr   = 1'b0;
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      n_vec++;
      if (cmplt_a[0] !== 1'b1 || err_a[0] !== 1'b1) begin
         n_miss++;
         $display("FAIL single_err_cmplt: cmplt=%b acc_err=%b exp 1 1", cmplt_a[0], err_a[0]);
      end
      n_vec++;
      if (cmplt_a[2] !== 1'b1 || dvld_a[2] !== 1'b1 || err_a[2] !== 1'b0) begin
         n_miss++;
         $display("FAIL single_ok_read: cmplt=%b data_vld=%b acc_err=%b exp 1 1 0",
                  cmplt_a[2], dvld_a[2], err_a[2]);
      end
      @(negedge clk);
      n_vec++;
      if (evld_a[0] !== 1'b1 || eaddr_a[0] !== 32'h1000 || ecnt_a[0] !== 8'd1 || ewr_a[0] !== 1'b0) begin
         n_miss++;
         $display("FAIL single_err_log: vld=%b addr=%h cnt=%0d wr=%b exp 1 00001000 1 0",
                  evld_a[0], eaddr_a[0], ecnt_a[0], ewr_a[0]);
      end
      idle(8);
   endtask

   task automatic test_back_to_back;
      for (int k = 0; k < 10; k++) begin
         automatic bit e_g = (k <= 8) && (k % 3 == 0);
         automatic bit e_c = (k > 0) && (k % 3 == 0);
         @(posedge clk); #1;
         req  = (k <= 8);
         addr = 32'h2000 + k;
         wr   = k[0];
         @(negedge clk);
         n_vec++;
         if (grnt_a[1] !== e_g || cmplt_a[1] !== e_c) begin
            n_miss++;
            $display("FAIL b2b_lat3 k=%0d: grnt=%b cmplt=%b exp %b %b", k, grnt_a[1], cmplt_a[1], e_g, e_c);
         end
      end
      idle(8);
   endtask

   task automatic test_deny;
      logic [7:0] cnt_before;
      @(posedge clk); #1;
      req  = 1'b1;
      addr = 32'h3000;
      wr   = 1'b0;
      @(negedge clk);
      cnt_before = m_cnt[0] + 8'd1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         deny = 1'b1;
         addr = 32'h3100 + k;
         @(negedge clk);
         n_vec++;
         if (grnt_a[0] !== 1'b1 || cmplt_a[0] !== (k == 0)) begin
            n_miss++;
            $display("FAIL deny k=%0d: grnt=%b cmplt=%b exp 1 %b", k, grnt_a[0], cmplt_a[0], k == 0);
         end
      end
      idle(3);
      @(negedge clk);
      n_vec++;
      if (ecnt_a[0] !== cnt_before || cmplt_a[0] !== 1'b0) begin
         n_miss++;
         $display("FAIL deny_cnt: cnt=%0d cmplt=%b exp %0d 0", ecnt_a[0], cmplt_a[0], cnt_before);
      end
      idle(6);
   endtask

   task automatic test_resp_ok;
      @(posedge clk); #1;
      req  = 1'b1;
      addr = 32'h30;
      wr   = 1'b0;
      @(posedge clk); #1;
      addr = 32'h34;
      wr   = 1'b1;
      @(negedge clk);
      n_vec++;
      if (cmplt_a[2] !== 1'b1 || dvld_a[2] !== 1'b1 || err_a[2] !== 1'b0 || data_a[2] !== 32'h0) begin
         n_miss++;
         $display("FAIL ok_read: cmplt=%b data_vld=%b acc_err=%b data=%h exp 1 1 0 0",
                  cmplt_a[2], dvld_a[2], err_a[2], data_a[2]);
      end
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      n_vec++;
      if (cmplt_a[2] !== 1'b1 || dvld_a[2] !== 1'b0 || err_a[2] !== 1'b0) begin
         n_miss++;
         $display("FAIL ok_write: cmplt=%b data_vld=%b acc_err=%b exp 1 0 0", cmplt_a[2], dvld_a[2], err_a[2]);
      end
      idle(2);
      @(negedge clk);
      n_vec++;
      if (evld_a[2] !== 1'b0 || ecnt_a[2] !== 8'd0) begin
         n_miss++;
         $display("FAIL ok_no_log: vld=%b cnt=%0d exp 0 0", evld_a[2], ecnt_a[2]);
      end
      idle(6);
   endtask

   task automatic test_saturate;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         req  = 1'b1;
         addr = 32'h100 + k;
         wr   = k[0];
      end
      idle(8);
      @(negedge clk);
      n_vec++;
      if (ecnt_a[0] !== 8'd255 || evld_a[0] !== 1'b1) begin
         n_miss++;
         $display("FAIL saturate: cnt=%0d vld=%b exp 255 1", ecnt_a[0], evld_a[0]);
      end
      @(posedge clk); #1;
      req  = 1'b1;
      addr = 32'hABC0;
      wr   = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      req = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      n_vec++;
      if (cmplt_a[0] !== 1'b1) begin
         n_miss++;
         $display("FAIL clr_coincide_cmplt: cmplt=%b exp 1", cmplt_a[0]);
      end
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      n_vec++;
      if (ecnt_a[0] !== 8'd1 || evld_a[0] !== 1'b1 || eaddr_a[0] !== 32'hABC0 || ewr_a[0] !== 1'b1) begin
         n_miss++;
         $display("FAIL clr_coincide_log: cnt=%0d vld=%b addr=%h wr=%b exp 1 1 0000abc0 1",
                  ecnt_a[0], evld_a[0], eaddr_a[0], ewr_a[0]);
      end
      idle(8);
   endtask

   task automatic test_reset_wait;
      @(posedge clk); #1;
      req  = 1'b1;
      addr = 32'h5000;
      wr   = 1'b0;
      @(posedge clk); #1;
      req = 1'b1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (grnt_a[3] !== 1'b0 || cmplt_a[3] !== 1'b0 || evld_a[3] !== 1'b0 ||
          ecnt_a[3] !== 8'd0 || eaddr_a[3] !== 32'h0 || grnt_a[0] !== 1'b0) begin
         n_miss++;
         $display("FAIL reset_in_wait: grnt=%b cmplt=%b vld=%b cnt=%0d addr=%h grnt0=%b exp all 0",
                  grnt_a[3], cmplt_a[3], evld_a[3], ecnt_a[3], eaddr_a[3], grnt_a[0]);
      end
      req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         n_vec++;
         if (cmplt_a[3] !== 1'b0) begin
            n_miss++;
            $display("FAIL abandoned k=%0d: cmplt=%b exp 0", k, cmplt_a[3]);
         end
      end
   endtask

   initial begin
      cyc    = 0;
      n_vec  = 0;
      n_miss = 0;
      rst_n  = 1'b0;
      req    = 1'b0;
      deny   = 1'b0;
      addr   = 32'h0;
      wr     = 1'b0;
      clr    = 1'b0;
      test_reset();
      test_single_err();
      test_back_to_back();
      test_deny();
      test_resp_ok();
      test_saturate();
      test_reset_wait();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/cr_tcipif_dummy_slave.md
CR_TCIPIF_DUMMY_SLAVE -- requirements
Module: cr_tcipif_dummy_slave

Interface
REQ-001 SHALL have parameter DW, 32, bus data width (8..64).
REQ-002 SHALL have parameter AW, 32, bus address width (8..32).
REQ-003 SHALL have parameter LAT, 1, accept-to-response latency in cycles (1..15).
REQ-004 SHALL have parameter RESP_ERR, 1, response mode: 1 = error response, 0 = OK response with zero read data.
REQ-005 SHALL have port forever_cpuclk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port cpurst_b  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port bmu_tcipif_bus_req  input  1  request valid.
REQ-008 SHALL have port bmu_tcipif_bus_acc_deny  input  1  request already denied upstream; no response is owed.
REQ-009 SHALL have port bmu_tcipif_bus_addr  input  AW  request address.
REQ-010 SHALL have port bmu_tcipif_bus_write  input  1  1 = write, 0 = read.
REQ-011 SHALL have port tcipif_err_clr  input  1  clear the error log.
REQ-012 SHALL have port tcipif_bmu_bus_grnt  output  1  request granted this cycle.
REQ-013 SHALL have port tcipif_bmu_bus_trans_cmplt  output  1  one-cycle completion pulse.
REQ-014 SHALL have port tcipif_bmu_bus_acc_err  output  1  completion carries an error.
REQ-015 SHALL have port tcipif_bmu_bus_data_vld  output  1  read data valid.
REQ-016 SHALL have port tcipif_bmu_bus_data  output  DW  read data, constant zero.
REQ-017 SHALL have port tcipif_err_vld  output  1  sticky flag: first error captured.
REQ-018 SHALL have port tcipif_err_addr  output  AW  address of first logged error.
REQ-019 SHALL have port tcipif_err_write  output  1  direction of first logged error.
REQ-020 SHALL have port tcipif_err_cnt  output  8  saturating error-response count.

Function
REQ-021 SHALL implement an FSM with states IDLE, WAIT and RESP; one transaction outstanding at most.
REQ-022 SHALL drive grnt = bus_req when state is IDLE or RESP, and 0 in WAIT.
REQ-023 SHALL accept a request in a cycle where grnt=1 and acc_deny=0; it SHALL capture addr and write into internal registers on that edge.
REQ-024 SHALL, for a granted request with acc_deny=1, issue no response and leave the state unchanged (IDLE remains IDLE, RESP goes to IDLE).
REQ-025 SHALL on accept go to RESP if LAT=1, else to WAIT with a 4-bit down-counter loaded with LAT-2.
REQ-026 SHALL in WAIT decrement the counter each cycle and go to RESP in the cycle after the counter reads 0.
REQ-027 SHALL assert trans_cmplt exactly in cycle T+LAT for a request accepted in cycle T; RESP lasts one cycle.
REQ-028 SHALL from RESP go to IDLE, or directly re-enter WAIT/RESP per REQ-025 when a new request is accepted, giving back-to-back throughput of one transaction per LAT cycles.
REQ-029 SHALL in RESP drive acc_err = RESP_ERR and data_vld = (!RESP_ERR && captured write==0); all three outputs SHALL be 0 outside RESP.
REQ-030 SHALL drive tcipif_bmu_bus_data to all zeros at all times.
REQ-031 SHALL, on each RESP cycle with RESP_ERR=1, increment err_cnt, saturating at 255.
REQ-032 SHALL, on such a RESP cycle with err_vld=0, load err_addr and err_write from the captured request and set err_vld; later errors SHALL NOT overwrite the log.
REQ-033 SHALL, when err_clr=1, clear err_vld and err_cnt to 0; err_addr and err_write SHALL hold their values.
REQ-034 SHALL, when err_clr coincides with an error RESP, give priority to the new error: err_vld=1, err_cnt=1, and err_addr/err_write are loaded.
REQ-035 SHALL never change err_vld or err_cnt when RESP_ERR=0.

Reset
REQ-036 SHALL on cpurst_b low immediately force state IDLE, counter 0, and all outputs 0, including err_vld, err_addr, err_write and err_cnt.
REQ-037 SHALL abandon any in-flight transaction on reset, with no trans_cmplt issued after reset is released.

Verification
REQ-038 SHALL cover: LAT=1, RESP_ERR=1, read accepted at cycle T to addr 0x1000 -> trans_cmplt=1 and acc_err=1 at T+1, err_vld=1, err_addr=0x1000, err_cnt=1.
REQ-039 SHALL cover: LAT=3, req held high for 3 transactions -> grnt at T, T+3, T+6; cmplt at T+3, T+6, T+9; grnt=0 in WAIT cycles.
REQ-040 SHALL cover: req=1 with acc_deny=1 -> grnt=1, no trans_cmplt, err_cnt unchanged.
REQ-041 SHALL cover: RESP_ERR=0, read then write -> read cmplt with data_vld=1, data=0, acc_err=0; write cmplt with data_vld=0; err_vld stays 0.
REQ-042 SHALL cover: 300 error transactions -> err_cnt=255; then err_clr coincident with an error RESP -> err_cnt=1, err_vld=1, err_addr = that error's address.
REQ-043 SHALL cover: LAT=5, cpurst_b asserted during WAIT -> outputs 0 immediately, and no cmplt within 10 cycles after release while req=0.
